// File: rtl/game_timer_if.sv
// Handshake bundle for game_timer: tick/start/pause in, digits and flags out.
// master drives the controls (divider/score side); slave is the timer.
interface game_timer_if;
  logic       tick_in;
  logic       start;
  logic       pause;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       time_up;
  logic       expired;
  logic       warn;

  modport master (
    output tick_in,
    output start,
    output pause,
    input  sec_tens,
    input  sec_ones,
    input  running,
    input  time_up,
    input  expired,
    input  warn
  );

  modport slave (
    input  tick_in,
    input  start,
    input  pause,
    output sec_tens,
    output sec_ones,
    output running,
    output time_up,
    output expired,
    output warn
  );
endinterface

// File: rtl/game_timer.sv
// BCD round countdown driven by the 1 s toggle from the clock divider.
// Ports: clk, rst_n (sync, active low), bus (game_timer_if.slave):
//   in  tick_in, start, pause
//   out sec_tens, sec_ones, running, time_up, expired, warn
// Optional feature macro: GAME_TIMER_WARN_EN enables the low-time warn flag;
// without it warn is tied to 0 and no comparator is built.
module game_timer #(
  parameter int START_SECS = 60,
  parameter int WARN_SECS  = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  game_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam logic [3:0] START_T = 4'(START_SECS / 10);
  localparam logic [3:0] START_O = 4'(START_SECS % 10);

  logic       s1;
  logic       s2;
  logic       prev;
  logic [1:0] prime;
  logic       armed;
  logic       tick_pulse;

  state_t     state;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       time_up;
  logic       expired;
  logic       warn;

  state_t     nxt_state;
  logic [3:0] nxt_t;
  logic [3:0] nxt_o;
  logic       nxt_tu;
  logic       nxt_warn;

  logic [3:0] dec_t;
  logic [3:0] dec_o;
  logic       at_one;

  // Two-flop synchroniser plus a history flop; either edge of the
  // 1 s toggle is one second.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      prev  <= 1'b0;
      prime <= 2'd0;
    end else begin
      s1   <= bus.tick_in;
      s2   <= s1;
      prev <= s2;
      if (prime != 2'd3)
        prime <= prime + 2'd1;
    end
  end

  // The chain holds reset zeros for three clocks; a tick_in already high
  // at release would otherwise look like an edge.
  assign armed      = (prime == 2'd3);
  assign tick_pulse = armed & (s2 ^ prev);

  // BCD decrement that saturates at 00.
  always_comb begin
    dec_t = tens;
    dec_o = ones;
    if (ones != 4'd0) begin
      dec_o = ones - 4'd1;
    end else if (tens != 4'd0) begin
      dec_o = 4'd9;
      dec_t = tens - 4'd1;
    end
  end

  assign at_one = (tens == 4'd0) && (ones <= 4'd1);

  always_comb begin
    nxt_state = state;
    nxt_t     = tens;
    nxt_o     = ones;
    nxt_tu    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          nxt_state = RUN;
          nxt_t     = START_T;
          nxt_o     = START_O;
        end
      end
      RUN: begin
        if (bus.start) begin
          nxt_t = START_T;
          nxt_o = START_O;
        end else if (bus.pause) begin
          nxt_state = PAUSE;
        end else if (tick_pulse) begin
          if (at_one) begin
            nxt_state = DONE;
            nxt_t     = 4'd0;
            nxt_o     = 4'd0;
            nxt_tu    = 1'b1;
          end else begin
            nxt_t = dec_t;
            nxt_o = dec_o;
          end
        end
      end
      PAUSE: begin
        if (bus.start) begin
          nxt_state = RUN;
          nxt_t     = START_T;
          nxt_o     = START_O;
        end else if (!bus.pause) begin
          nxt_state = RUN;
        end
      end
      DONE: begin
        if (bus.start) begin
          nxt_state = RUN;
          nxt_t     = START_T;
          nxt_o     = START_O;
        end else begin
          nxt_t = 4'd0;
          nxt_o = 4'd0;
        end
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

`ifdef GAME_TIMER_WARN_EN
  logic [6:0] nxt_rem;

  assign nxt_rem  = 7'(nxt_t) * 7'd10 + 7'(nxt_o);
  assign nxt_warn = ((nxt_state == RUN) || (nxt_state == PAUSE))
                 && (nxt_rem <= 7'(WARN_SECS));
`else
  assign nxt_warn = 1'b0;
`endif

  // Flags are decoded from the next state so they line up with the digits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      tens    <= START_T;
      ones    <= START_O;
      running <= 1'b0;
      time_up <= 1'b0;
      expired <= 1'b0;
      warn    <= 1'b0;
    end else begin
      state   <= nxt_state;
      tens    <= nxt_t;
      ones    <= nxt_o;
      running <= (nxt_state == RUN);
      time_up <= nxt_tu;
      expired <= (nxt_state == DONE);
      warn    <= nxt_warn;
    end
  end

  assign bus.sec_tens = tens;
  assign bus.sec_ones = ones;
  assign bus.running  = running;
  assign bus.time_up  = time_up;
  assign bus.expired  = expired;
  assign bus.warn     = warn;

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: START_SECS=3 and START_SECS=10 instances, WARN_SECS=1,
// driven in lockstep and checked against a seconds-count reference model.
module tb_game_timer;

`ifdef GAME_TIMER_WARN_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  localparam int SS [2] = '{3, 10};

  logic clk = 1'b0;
  logic rst_n;
  logic tick;
  logic start;
  logic pause;

  int n_cmp = 0;
  int n_bad = 0;

  game_timer_if b3 ();
  game_timer_if b10 ();

  assign b3.tick_in  = tick;
  assign b3.start    = start;
  assign b3.pause    = pause;
  assign b10.tick_in = tick;
  assign b10.start   = start;
  assign b10.pause   = pause;

  game_timer #(.START_SECS(3), .WARN_SECS(1)) u3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3)
  );

  game_timer #(.START_SECS(10), .WARN_SECS(1)) u10 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b10)
  );

  always #5 clk = ~clk;

  // Reference model: whole seconds remaining, mode 0 idle/1 run/2 pause/3 done.
  int m_mode [2];
  int m_rem  [2];
  bit m_tu   [2];
  bit h0, h1, h2;
  int since;

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit pulse;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0;
        m_rem[i]  = SS[i];
        m_tu[i]   = 1'b0;
      end
      h0 = 0; h1 = 0; h2 = 0;
      since = 0;
    end else begin
      // a second is seen when the sample from 2 edges ago differs from 3 ago
      pulse = (since >= 3) && (h1 != h2);
      h2 = h1; h1 = h0; h0 = tick;
      if (since < 3) since++;
      for (int i = 0; i < 2; i++) begin
        m_tu[i] = 1'b0;
        case (m_mode[i])
          0: if (start) begin m_mode[i] = 1; m_rem[i] = SS[i]; end
          1: begin
            if (start) m_rem[i] = SS[i];
            else if (pause) m_mode[i] = 2;
            else if (pulse && m_rem[i] > 0) begin
              m_rem[i]--;
              if (m_rem[i] == 0) begin
                m_mode[i] = 3;
                m_tu[i]   = 1'b1;
              end
            end
          end
          2: begin
            if (start) begin m_mode[i] = 1; m_rem[i] = SS[i]; end
            else if (!pause) m_mode[i] = 1;
          end
          default: if (start) begin m_mode[i] = 1; m_rem[i] = SS[i]; end
        endcase
      end
    end
  endtask

  task automatic cmp_inst(string tag, int i, logic [3:0] t, logic [3:0] o,
                          logic r, logic tu, logic ex, logic w);
    bit ew;
    ew = WEN && (m_mode[i] == 1 || m_mode[i] == 2) && (m_rem[i] <= 1);
    chk({tag, ".tens"}, 8'(t), 8'(m_rem[i] / 10));
    chk({tag, ".ones"}, 8'(o), 8'(m_rem[i] % 10));
    chk({tag, ".running"}, 8'(r), 8'(m_mode[i] == 1));
    chk({tag, ".time_up"}, 8'(tu), 8'(m_tu[i]));
    chk({tag, ".expired"}, 8'(ex), 8'(m_mode[i] == 3));
    chk({tag, ".warn"}, 8'(w), 8'(ew));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_inst("m3", 0, b3.sec_tens, b3.sec_ones, b3.running,
             b3.time_up, b3.expired, b3.warn);
    cmp_inst("m10", 1, b10.sec_tens, b10.sec_ones, b10.running,
             b10.time_up, b10.expired, b10.warn);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; pause = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic tick_edge(int n);
    tick = ~tick;
    repeat (n) step();
  endtask

  task automatic chk_dig(string name, logic [3:0] t, logic [3:0] o, int v);
    chk({name, ".tens"}, 8'(t), 8'(v / 10));
    chk({name, ".ones"}, 8'(o), 8'(v % 10));
  endtask

  typedef struct {
    bit rn, st, pa, tk;
    int val;
    bit run, tu, ex, wr;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(bit rn, bit st, bit pa, bit tk, int val,
                              bit run, bit tu, bit ex, bit wr);
    vec_t v;
    v.rn = rn; v.st = st; v.pa = pa; v.tk = tk; v.val = val;
    v.run = run; v.tu = tu; v.ex = ex; v.wr = wr;
    return v;
  endfunction

  initial begin
    int gap;
    rst_n = 1'b0; tick = 1'b0; start = 1'b0; pause = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_rem[i] = SS[i]; m_tu[i] = 0;
    end
    h0 = 0; h1 = 0; h2 = 0; since = 0;

    // full round on the 3 s instance, then restart from DONE
    tbl[0]  = mk(0, 0, 0, 0, 3, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 3, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 3, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 3, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 3, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0, 3, 1, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 1, 3, 1, 0, 0, 0);
    tbl[7]  = mk(1, 0, 0, 1, 3, 1, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 1, 2, 1, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 0, 2, 1, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 2, 1, 0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 1, 1, 0, 0, 1);
    tbl[12] = mk(1, 0, 0, 1, 1, 1, 0, 0, 1);
    tbl[13] = mk(1, 0, 0, 1, 1, 1, 0, 0, 1);
    tbl[14] = mk(1, 0, 0, 1, 0, 0, 1, 1, 0);
    tbl[15] = mk(1, 0, 0, 1, 0, 0, 0, 1, 0);
    tbl[16] = mk(1, 1, 0, 1, 3, 1, 0, 0, 0);
    tbl[17] = mk(1, 0, 0, 1, 3, 1, 0, 0, 0);

    for (int k = 0; k < 18; k++) begin
      string n;
      rst_n = tbl[k].rn; start = tbl[k].st;
      pause = tbl[k].pa; tick = tbl[k].tk;
      step();
      n = $sformatf("tbl%0d", k);
      chk_dig(n, b3.sec_tens, b3.sec_ones, tbl[k].val);
      chk({n, ".running"}, 8'(b3.running), 8'(tbl[k].run));
      chk({n, ".time_up"}, 8'(b3.time_up), 8'(tbl[k].tu));
      chk({n, ".expired"}, 8'(b3.expired), 8'(tbl[k].ex));
      chk({n, ".warn"}, 8'(b3.warn), 8'(tbl[k].wr & WEN));
    end
    start = 1'b0;

    // tick_in held high across reset release must not count a second
    tick = 1'b1;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) step();
    chk_dig("hold_idle", b3.sec_tens, b3.sec_ones, 3);
    chk("hold_idle.running", 8'(b3.running), 8'd0);
    pulse_start();
    repeat (10) step();
    chk_dig("hold_run", b3.sec_tens, b3.sec_ones, 3);

    // pause discards ticks
    tick = 1'b0;
    do_reset();
    pulse_start();
    tick_edge(20);
    chk_dig("pre_pause", b3.sec_tens, b3.sec_ones, 2);
    pause = 1'b1;
    step();
    tick_edge(20);
    tick_edge(20);
    chk_dig("paused", b3.sec_tens, b3.sec_ones, 2);
    chk("paused.running", 8'(b3.running), 8'd0);
    pause = 1'b0;
    step();
    chk("resume.running", 8'(b3.running), 8'd1);
    tick_edge(20);
    chk_dig("resumed", b3.sec_tens, b3.sec_ones, 1);

    // start on the cycle the tick pulse lands
    do_reset();
    pulse_start();
    tick_edge(20);
    tick = ~tick;
    repeat (2) step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk_dig("coincide", b3.sec_tens, b3.sec_ones, 3);
    repeat (20) step();
    chk_dig("coincide_after", b3.sec_tens, b3.sec_ones, 3);

    // 10 -> 09 borrow, then down to 01 for warn
    do_reset();
    pulse_start();
    chk_dig("ten_start", b10.sec_tens, b10.sec_ones, 10);
    tick_edge(20);
    chk_dig("borrow", b10.sec_tens, b10.sec_ones, 9);
    chk("borrow.warn", 8'(b10.warn), 8'd0);
    for (int k = 0; k < 8; k++) tick_edge(20);
    chk_dig("ten_one", b10.sec_tens, b10.sec_ones, 1);
    chk("ten_one.warn", 8'(b10.warn), 8'(WEN));
    chk("u3_done.expired", 8'(b3.expired), 8'd1);

    // randomized traffic against the model
    do_reset();
    gap = 5;
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      start = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      if (gap == 0) begin
        tick = ~tick;
        gap = $urandom_range(2, 25);
      end else begin
        gap--;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
